display_scan: RTL and testbench

Multi-digit scanner sitting directly upstream of the 7-segment `display` decoder. It holds a frame of `DIGITS` 4-bit codes plus decimal points, time-multiplexes them onto the decoder's single 4-bit `data` input, and drives one active-low digit-enable per digit. A blanking gap at each digit change prevents ghosting. New frames load tear-free at frame boundaries.

---
 rtl/display_scan.sv | 138 +++++++++++++
 tb/tb_display_scan.sv | 137 +++++++++++++
 2 files changed

// File: rtl/display_scan.sv
// Multiplexed 7-segment digit scanner with tear-free frame loading.
// Define DISPLAY_SCAN_LZS_EN to enable leading-zero suppression.
module display_scan #(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [4*DIGITS-1:0]   digits_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  load,
    output logic [3:0]            data,
    output logic                  dp_sel,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int CW = $clog2(SCAN_DIV);
    localparam int IW = $clog2(DIGITS);

    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

    localparam logic [0:0] ST_BLANK = 1'b0;
    localparam logic [0:0] ST_SHOW  = 1'b1;
    localparam logic [0:0] ST_START = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    logic [4*DIGITS-1:0] shadow_codes, active_codes, active_codes_nxt;
    logic [DIGITS-1:0]   shadow_dp, active_dp, active_dp_nxt;
    logic                pending, pending_nxt;
    logic [CW-1:0]       cnt, cnt_nxt;
    logic [IW-1:0]       idx, idx_nxt;
    logic [0:0]          state, state_nxt;

    logic                slot_end, frame_end;
    logic [3:0]          code_nxt;
    logic                dp_nxt;
    logic                suppress;
    logic [DIGITS-1:0]   an_nxt;

    // Outputs are registered from next-state values so they line up with cnt/idx.
    always_comb begin
        // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
        slot_end         = (cnt == CNT_LAST);
        frame_end        = slot_end && (idx == IDX_LAST);
        cnt_nxt          = slot_end ? '0 : cnt + CW'(1);
        idx_nxt          = idx;
        state_nxt        = state;
        active_codes_nxt = active_codes;
        active_dp_nxt    = active_dp;
        pending_nxt      = pending;

        if (slot_end) begin
            idx_nxt   = (idx == IDX_LAST) ? '0 : idx + IW'(1);
            state_nxt = ST_START;
        end else if (cnt_nxt == CNT_SHOW) begin
            state_nxt = ST_SHOW;
        end

        // A load landing on the frame-end cycle bypasses the shadow entirely.
        if (frame_end) begin
            pending_nxt = 1'b0;
            if (load) begin
                active_codes_nxt = digits_in;
                active_dp_nxt    = dp_in;
            end else if (pending) begin
                active_codes_nxt = shadow_codes;
                active_dp_nxt    = shadow_dp;
            end
        end else if (load) begin
            pending_nxt = 1'b1;
        end
    end

    always_comb begin
        code_nxt = 4'd0;
        dp_nxt   = 1'b0;
        suppress = 1'b0;
`ifdef DISPLAY_SCAN_LZS_EN
        begin
            logic zero_above;
            zero_above = 1'b1;
            // Walk from the most significant digit so zero_above covers this digit and all above it.
            for (int k = DIGITS - 1; k >= 0; k--) begin
                zero_above = zero_above && (active_codes_nxt[4*k +: 4] == 4'd0);
                if (IW'(k) == idx_nxt)
                    suppress = zero_above && (k != 0) && !active_dp_nxt[k];
            end
        end
`endif
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx_nxt) begin
                code_nxt = active_codes_nxt[4*k +: 4];
                dp_nxt   = active_dp_nxt[k];
            end
        end

        an_nxt = '1;
        if (state_nxt == ST_SHOW && !suppress)
            an_nxt[idx_nxt] = 1'b0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shadow_codes <= '0;
            shadow_dp    <= '0;
            active_codes <= '0;
            active_dp    <= '0;
            pending      <= 1'b0;
            cnt          <= '0;
            idx          <= '0;
            state        <= ST_START;
            data         <= 4'd0;
            dp_sel       <= 1'b0;
            an           <= '1;
            frame_done   <= 1'b0;
        end else begin
            if (load) begin
                shadow_codes <= digits_in;
                shadow_dp    <= dp_in;
            end
            active_codes <= active_codes_nxt;
            active_dp    <= active_dp_nxt;
            pending      <= pending_nxt;
            cnt          <= cnt_nxt;
            idx          <= idx_nxt;
            state        <= state_nxt;
            data         <= code_nxt;
            dp_sel       <= dp_nxt;
            an           <= an_nxt;
            frame_done   <= (cnt_nxt == CNT_LAST) && (idx_nxt == IDX_LAST);
        end
    end

endmodule

// File: tb/tb_display_scan.sv
// Directed bench for display_scan with DIGITS=4, SCAN_DIV=8, BLANK_CYCLES=2.
module tb_display_scan;

`ifdef DISPLAY_SCAN_LZS_EN
    localparam bit LZS = 1'b1;
`else
    localparam bit LZS = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [15:0] digits_in = '0;
    logic [3:0]  dp_in = '0;
    logic        load = 1'b0;
    logic [3:0]  data;
    logic        dp_sel;
    logic [3:0]  an;
    logic        frame_done;

    int passed = 0;
    int total  = 0;

    always #5 clock = ~clock;

    display_scan #(.DIGITS(4), .SCAN_DIV(8), .BLANK_CYCLES(2)) dut (
        .clock      (clock),
        .reset      (reset),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .load       (load),
        .data       (data),
        .dp_sel     (dp_sel),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Checks one full slot starting at cnt=0; optionally pulses load at cnt=ld_at.
    task automatic check_slot(input int fr, input int slot, input logic [3:0] exp_data,
                              input logic [3:0] exp_an, input logic exp_dp, input int ld_at,
                              input logic [15:0] ld_d, input logic [3:0] ld_dp);
        for (int i = 0; i < 8; i++) begin
            string tag;
            tag = $sformatf("f%0d s%0d c%0d", fr, slot, i);
            check({tag, " data"}, 16'(data), 16'(exp_data));
            check({tag, " dp_sel"}, 16'(dp_sel), 16'(exp_dp));
            check({tag, " an"}, 16'(an), (i < 2) ? 16'hF : 16'(exp_an));
            check({tag, " frame_done"}, 16'(frame_done), 16'(i == 7 && slot == 3));
            if (i == ld_at) begin
                load = 1'b1;
                digits_in = ld_d;
                dp_in = ld_dp;
            end
            @(negedge clock);
            load = 1'b0;
        end
    endtask

    initial begin
        #1 reset = 1'b1;
        @(negedge clock);
        check("reset an", 16'(an), 16'hF);
        check("reset data", 16'(data), 16'h0);
        check("reset dp_sel", 16'(dp_sel), 16'h0);
        check("reset frame_done", 16'(frame_done), 16'h0);
        @(negedge clock);
        reset = 1'b0;

        // Frame 0: all-zero frame; load 4321 for the next frame.
        check_slot(0, 0, 4'h0, 4'b1110, 1'b0, 3, 16'h4321, 4'b0100);
        check_slot(0, 1, 4'h0, LZS ? 4'b1111 : 4'b1101, 1'b0, -1, 16'h0, 4'h0);
        check_slot(0, 2, 4'h0, LZS ? 4'b1111 : 4'b1011, 1'b0, -1, 16'h0, 4'h0);
        check_slot(0, 3, 4'h0, LZS ? 4'b1111 : 4'b0111, 1'b0, -1, 16'h0, 4'h0);

        // Frame 1: scan order; a mid-frame load of 9999 must not tear.
        check_slot(1, 0, 4'h1, 4'b1110, 1'b0, -1, 16'h0, 4'h0);
        check_slot(1, 1, 4'h2, 4'b1101, 1'b0, 4, 16'h9999, 4'b0000);
        check_slot(1, 2, 4'h3, 4'b1011, 1'b1, -1, 16'h0, 4'h0);
        check_slot(1, 3, 4'h4, 4'b0111, 1'b0, -1, 16'h0, 4'h0);

        // Frame 2: 9999; early load 5555 is overridden by a frame-end load of 0070.
        check_slot(2, 0, 4'h9, 4'b1110, 1'b0, 2, 16'h5555, 4'b0000);
        check_slot(2, 1, 4'h9, 4'b1101, 1'b0, -1, 16'h0, 4'h0);
        check_slot(2, 2, 4'h9, 4'b1011, 1'b0, -1, 16'h0, 4'h0);
        check_slot(2, 3, 4'h9, 4'b0111, 1'b0, 7, 16'h0070, 4'b0000);

        // Frame 3: 0070.
        check_slot(3, 0, 4'h0, 4'b1110, 1'b0, 4, 16'h0000, 4'b0000);
        check_slot(3, 1, 4'h7, 4'b1101, 1'b0, -1, 16'h0, 4'h0);
        check_slot(3, 2, 4'h0, LZS ? 4'b1111 : 4'b1011, 1'b0, -1, 16'h0, 4'h0);
        check_slot(3, 3, 4'h0, LZS ? 4'b1111 : 4'b0111, 1'b0, -1, 16'h0, 4'h0);

        // Frame 4: 0000, only slot 0 lit under suppression.
        check_slot(4, 0, 4'h0, 4'b1110, 1'b0, 5, 16'h0000, 4'b1000);
        check_slot(4, 1, 4'h0, LZS ? 4'b1111 : 4'b1101, 1'b0, -1, 16'h0, 4'h0);
        check_slot(4, 2, 4'h0, LZS ? 4'b1111 : 4'b1011, 1'b0, -1, 16'h0, 4'h0);
        check_slot(4, 3, 4'h0, LZS ? 4'b1111 : 4'b0111, 1'b0, -1, 16'h0, 4'h0);

        // Frame 5: 0000 with dp on digit 3 keeps slot 3 lit.
        check_slot(5, 0, 4'h0, 4'b1110, 1'b0, 1, 16'hFA0B, 4'b0001);
        check_slot(5, 1, 4'h0, LZS ? 4'b1111 : 4'b1101, 1'b0, -1, 16'h0, 4'h0);
        check_slot(5, 2, 4'h0, LZS ? 4'b1111 : 4'b1011, 1'b0, -1, 16'h0, 4'h0);
        check_slot(5, 3, 4'h0, 4'b0111, 1'b1, -1, 16'h0, 4'h0);

        // Frame 6: codes 10-15 pass through; inner zero stays lit.
        check_slot(6, 0, 4'hB, 4'b1110, 1'b1, -1, 16'h0, 4'h0);
        check_slot(6, 1, 4'h0, 4'b1101, 1'b0, -1, 16'h0, 4'h0);
        check_slot(6, 2, 4'hA, 4'b1011, 1'b0, -1, 16'h0, 4'h0);
        check_slot(6, 3, 4'hF, 4'b0111, 1'b0, -1, 16'h0, 4'h0);

        // Frame 7: reset asserted at cnt=5 of slot 1, between clock edges.
        check_slot(7, 0, 4'hB, 4'b1110, 1'b1, -1, 16'h0, 4'h0);
        repeat (5) @(negedge clock);
        check("mid an before reset", 16'(an), 16'b1101);
        #2 reset = 1'b1;
        #1;
        check("mid reset an", 16'(an), 16'hF);
        check("mid reset data", 16'(data), 16'h0);
        check("mid reset dp_sel", 16'(dp_sel), 16'h0);
        check("mid reset frame_done", 16'(frame_done), 16'h0);
        @(negedge clock);
        reset = 1'b0;

        // Restart at idx 0 with a cleared frame.
        check_slot(8, 0, 4'h0, 4'b1110, 1'b0, -1, 16'h0, 4'h0);
        check_slot(8, 1, 4'h0, LZS ? 4'b1111 : 4'b1101, 1'b0, -1, 16'h0, 4'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
